// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcode map, encodings and control word for control_unit (ILLEGAL_OP_EN adds illegal flag)
package control_unit_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALU_W    = 5;

    localparam logic [1:0] CLS_SREG = 2'b00;
    localparam logic [1:0] CLS_SIMM = 2'b01;
    localparam logic [1:0] CLS_MEMV = 2'b10;
    localparam logic [1:0] CLS_BR   = 2'b11;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 6'h20;
    localparam logic [OPCODE_W-1:0] OP_STORE = 6'h21;
    localparam logic [OPCODE_W-1:0] OP_B     = 6'h30;
    localparam logic [OPCODE_W-1:0] OP_BL    = 6'h31;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I12  = 2'b01;
    localparam logic [1:0] IMM_B20  = 2'b10;

    localparam logic [ALU_W-1:0] ALU_ADD   = 5'h00;
    localparam logic [ALU_W-1:0] ALU_PASSA = 5'h0F;

    typedef struct packed {
        logic             pc_src;
        logic             mem_to_reg;
        logic             mem_write;
        logic [ALU_W-1:0] alu_control;
        logic [1:0]       imm_src;
        logic             reg_write;
`ifdef ILLEGAL_OP_EN
        logic             illegal_op;
`endif
    } ctrl_word_t;

endpackage

// File: rtl/control_unit_decoder.sv
// rtl/control_unit_decoder.sv - combinational opcode to control word decode (ILLEGAL_OP_EN flags reserved opcodes)
module control_decoder
    import control_unit_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_word_t          o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_opcode[5:4])
            CLS_SREG: begin
                if (i_opcode != OP_NOP) begin
                    o_ctrl.alu_control = {1'b0, i_opcode[3:0]};
                    o_ctrl.reg_write   = 1'b1;
                    o_ctrl.imm_src     = IMM_NONE;
                end
            end
            CLS_SIMM: begin
                o_ctrl.alu_control = {1'b0, i_opcode[3:0]};
                o_ctrl.reg_write   = 1'b1;
                o_ctrl.imm_src     = IMM_I12;
            end
            CLS_MEMV: begin
                if (i_opcode == OP_LOAD) begin
                    o_ctrl.alu_control = ALU_ADD;
                    o_ctrl.imm_src     = IMM_I12;
                    o_ctrl.mem_to_reg  = 1'b1;
                    o_ctrl.reg_write   = 1'b1;
                end else if (i_opcode == OP_STORE) begin
                    o_ctrl.alu_control = ALU_ADD;
                    o_ctrl.imm_src     = IMM_I12;
                    o_ctrl.mem_write   = 1'b1;
                end else begin
                    o_ctrl.alu_control = {1'b1, i_opcode[3:0]};
                    o_ctrl.reg_write   = 1'b1;
                end
            end
            CLS_BR: begin
                if (i_opcode == OP_B) begin
                    o_ctrl.pc_src      = 1'b1;
                    o_ctrl.imm_src     = IMM_B20;
                    o_ctrl.alu_control = ALU_ADD;
                end else if (i_opcode == OP_BL) begin
                    o_ctrl.pc_src      = 1'b1;
                    o_ctrl.imm_src     = IMM_B20;
                    o_ctrl.reg_write   = 1'b1;
                    o_ctrl.alu_control = ALU_PASSA;
                end else begin
                    // 0x32-0x3F are reserved: control fields stay NOP
`ifdef ILLEGAL_OP_EN
                    o_ctrl.illegal_op = 1'b1;
`endif
                end
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - main decoder with one registered stage; ILLEGAL_OP_EN adds the illegal_op output
module control_unit
    import control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_src,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic [ALU_W-1:0]    alu_control,
    output logic [1:0]          imm_src,
`ifdef ILLEGAL_OP_EN
    output logic                illegal_op,
`endif
    output logic                reg_write
);

    ctrl_word_t w_ctrl;
    ctrl_word_t r_ctrl;

    control_decoder u_decoder (
        .i_opcode (opcode),
        .o_ctrl   (w_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign pc_src      = r_ctrl.pc_src;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign mem_write   = r_ctrl.mem_write;
    assign alu_control = r_ctrl.alu_control;
    assign imm_src     = r_ctrl.imm_src;
    assign reg_write   = r_ctrl.reg_write;
`ifdef ILLEGAL_OP_EN
    assign illegal_op  = r_ctrl.illegal_op;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit (honours ILLEGAL_OP_EN)
module tb_control_unit;

`ifdef ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0] op;
        logic       pc;
        logic       m2r;
        logic       mw;
        logic [4:0] alu;
        logic [1:0] imm;
        logic       rw;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       pc_src, mem_to_reg, mem_write, reg_write;
    logic [4:0] alu_control;
    logic [1:0] imm_src;
    logic       ill_out;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[16];

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .pc_src      (pc_src),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .alu_control (alu_control),
        .imm_src     (imm_src),
`ifdef ILLEGAL_OP_EN
        .illegal_op  (ill_out),
`endif
        .reg_write   (reg_write)
    );

`ifndef ILLEGAL_OP_EN
    assign ill_out = 1'b0;
`endif

    function automatic vec_t mk(input logic [5:0] op, input logic pc, input logic m2r,
                                input logic mw, input logic [4:0] alu, input logic [1:0] imm,
                                input logic rw, input logic ill);
        vec_t v;
        v.op = op; v.pc = pc; v.m2r = m2r; v.mw = mw;
        v.alu = alu; v.imm = imm; v.rw = rw; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t ref_model(input logic [5:0] op);
        int o = int'(op);
        vec_t v = mk(op, 0, 0, 0, 5'h00, 2'b00, 0, 0);
        if (o >= 1 && o <= 15)            v = mk(op, 0, 0, 0, 5'(o), 2'b00, 1, 0);
        else if (o >= 16 && o <= 31)      v = mk(op, 0, 0, 0, 5'(o - 16), 2'b01, 1, 0);
        else if (o == 32)                 v = mk(op, 0, 1, 0, 5'h00, 2'b01, 1, 0);
        else if (o == 33)                 v = mk(op, 0, 0, 1, 5'h00, 2'b01, 0, 0);
        else if (o >= 34 && o <= 47)      v = mk(op, 0, 0, 0, 5'(o - 32 + 16), 2'b00, 1, 0);
        else if (o == 48)                 v = mk(op, 1, 0, 0, 5'h00, 2'b10, 0, 0);
        else if (o == 49)                 v = mk(op, 1, 0, 0, 5'h0F, 2'b10, 1, 0);
        else if (o >= 50)                 v = mk(op, 0, 0, 0, 5'h00, 2'b00, 0, ILL_EN);
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [11:0] got, exp;
        got = {pc_src, mem_to_reg, mem_write, alu_control, imm_src, reg_write, ill_out};
        exp = {e.pc, e.m2r, e.mw, e.alu, e.imm, e.rw, e.ill};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s op=%02h got pc/m2r/mw/alu/imm/rw/ill=%b/%b/%b/%02h/%b/%b/%b required %b/%b/%b/%02h/%b/%b/%b",
                     name, e.op, pc_src, mem_to_reg, mem_write, alu_control, imm_src, reg_write, ill_out,
                     e.pc, e.m2r, e.mw, e.alu, e.imm, e.rw, e.ill);
        end
    endtask

    task automatic check_inv(input logic [5:0] op);
        n_vec++;
        if ((mem_write && reg_write) || (mem_to_reg && !reg_write)) begin
            n_err++;
            $display("FAIL invariant op=%02h got mw=%b rw=%b m2r=%b required not(mw&rw) and m2r->rw",
                     op, mem_write, reg_write, mem_to_reg);
        end
    endtask

    initial begin
        vec_t nop_w, load_w, store_w, b_w;
        nop_w   = mk(6'h00, 0, 0, 0, 5'h00, 2'b00, 0, 0);
        load_w  = mk(6'h20, 0, 1, 0, 5'h00, 2'b01, 1, 0);
        store_w = mk(6'h21, 0, 0, 1, 5'h00, 2'b01, 0, 0);
        b_w     = mk(6'h30, 1, 0, 0, 5'h00, 2'b10, 0, 0);

        tbl[0]  = nop_w;
        tbl[1]  = mk(6'h05, 0, 0, 0, 5'h05, 2'b00, 1, 0);
        tbl[2]  = mk(6'h15, 0, 0, 0, 5'h05, 2'b01, 1, 0);
        tbl[3]  = load_w;
        tbl[4]  = store_w;
        tbl[5]  = mk(6'h2A, 0, 0, 0, 5'h1A, 2'b00, 1, 0);
        tbl[6]  = b_w;
        tbl[7]  = mk(6'h31, 1, 0, 0, 5'h0F, 2'b10, 1, 0);
        tbl[8]  = mk(6'h3F, 0, 0, 0, 5'h00, 2'b00, 0, ILL_EN);
        tbl[9]  = mk(6'h01, 0, 0, 0, 5'h01, 2'b00, 1, 0);
        tbl[10] = mk(6'h0F, 0, 0, 0, 5'h0F, 2'b00, 1, 0);
        tbl[11] = mk(6'h10, 0, 0, 0, 5'h00, 2'b01, 1, 0);
        tbl[12] = mk(6'h1F, 0, 0, 0, 5'h0F, 2'b01, 1, 0);
        tbl[13] = mk(6'h22, 0, 0, 0, 5'h12, 2'b00, 1, 0);
        tbl[14] = mk(6'h2F, 0, 0, 0, 5'h1F, 2'b00, 1, 0);
        tbl[15] = mk(6'h32, 0, 0, 0, 5'h00, 2'b00, 0, ILL_EN);

        // Reset with LOAD on the bus: outputs must be NOP without any edge
        rst_n  = 1'b0;
        opcode = 6'h20;
        #2;
        check("reset_no_edge", nop_w);
        @(posedge clk); #1;
        check("reset_held", nop_w);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_load", load_w);

        // Mid-stream async reset clears outputs between edges
        opcode = 6'h21;
        @(posedge clk); #1;
        check("pre_reset_store", store_w);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", nop_w);
        opcode = 6'h30;
        #1 rst_n = 1'b1;
        #1;
        check("released_no_edge", nop_w);
        @(posedge clk); #1;
        check("first_post_release", b_w);

        // Latency: new opcode must not appear before the next edge
        opcode = 6'h21;
        #3;
        check("latency_hold", b_w);
        @(posedge clk); #1;
        check("latency_one", store_w);

        foreach (tbl[i]) begin
            opcode = tbl[i].op;
            @(posedge clk); #1;
            check("table", tbl[i]);
            check_inv(tbl[i].op);
        end

        for (int k = 0; k < 64; k++) begin
            opcode = 6'(k);
            @(posedge clk); #1;
            check("sweep", ref_model(6'(k)));
            check_inv(6'(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
